mem_bus_if: RTL and testbench
=============================

Name: mem_bus_if

Overview:
- Memory bus interface between the CPU controller strobes (rd, wr, sel, data_e) and a variable-latency external memory with a req/ack handshake.
- Turns each controller read or write phase into exactly one memory transaction.
- Latches the address (PC or IR operand) and returns read data to the IR/ALU path.
- Asserts stall so the controller phase counter freezes until the memory answers.
- Detects handshake timeouts and illegal strobe combinations.

Parameters:
- ADDR_WIDTH, 5, width of pc_addr, ir_addr and mem_addr.
- DATA_WIDTH, 8, width of accumulator and memory data.
- TIMEOUT, 15, maximum cycles mem_req may stay unacknowledged; legal range 1..255.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- rd  input  1  controller memory-read strobe.
- wr  input  1  controller memory-write strobe.
- sel  input  1  address select: 1 = pc_addr, 0 = ir_addr.
- data_e  input  1  controller data-bus enable; must be 1 when a write starts.
- pc_addr  input  ADDR_WIDTH  program counter value.
- ir_addr  input  ADDR_WIDTH  operand address field of the IR.
- ac_out  input  DATA_WIDTH  accumulator value to store.
- mem_addr  output  ADDR_WIDTH  registered memory address.
- mem_req  output  1  memory request, held until acknowledged.
- mem_we  output  1  1 = write transaction, 0 = read; valid while mem_req=1.
- mem_wdata  output  DATA_WIDTH  registered write data.
- mem_rdata  input  DATA_WIDTH  memory read data; valid when mem_ack=1.
- mem_ack  input  1  memory acknowledge; may be combinational from mem_req (zero-wait memory).
- rdata  output  DATA_WIDTH  last successfully read word; held between reads.
- rdata_valid  output  1  one-cycle pulse when rdata updates.
- stall  output  1  freeze request to controller.
- bus_err  output  1  sticky error flag.

Behaviour:
- Reset (asynchronous, immediate, also mid-transaction):
  - State IDLE; mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - rdata=0, rdata_valid=0, stall=0, bus_err=0.
  - rd_q=0, wr_q=0, timeout counter=0.
  - Any outstanding transaction is abandoned without completing.
- Edge detect:
  - rd_q and wr_q register rd and wr every cycle.
  - start_rd = rd & ~rd_q; start_wr = wr & ~wr_q.
  - A strobe held high for several controller states starts only one transaction.
- States: IDLE, RD_WAIT, WR_WAIT, ERR.
- IDLE:
  - start_rd only, at edge E: mem_addr <= (sel ? pc_addr : ir_addr), mem_we <= 0, mem_req <= 1, go to RD_WAIT.
  - start_wr with data_e=1, at edge E: mem_addr latched as above, mem_wdata <= ac_out, mem_we <= 1, mem_req <= 1, go to WR_WAIT.
  - start_wr with data_e=0: bus_err <= 1, no transaction, stay IDLE.
  - start_rd and start_wr in the same cycle: bus_err <= 1, no transaction, stay IDLE.
- RD_WAIT / WR_WAIT:
  - Counter increments each cycle mem_ack=0.
  - At the edge where mem_ack=1 is sampled: mem_req <= 0, mem_we <= 0, counter <= 0, go to IDLE.
  - In RD_WAIT that edge also loads rdata <= mem_rdata and sets rdata_valid=1 for exactly the following cycle.
  - If the counter reaches TIMEOUT with mem_ack still 0: mem_req <= 0, bus_err <= 1, go to ERR. rdata is unchanged and no rdata_valid pulse is produced.
- ERR: stall=0, mem_req=0. Return to IDLE on the next edge; bus_err remains set.
- bus_err clears only on reset.
- stall is combinational: stall = (state==RD_WAIT) | (state==WR_WAIT).
  - Zero-wait memory gives stall high for exactly 1 cycle per transaction.
  - N wait cycles give stall high for N+1 cycles.
- Edges of rd or wr while in RD_WAIT/WR_WAIT are ignored. rd_q/wr_q still track the strobes, so an edge that occurs during a wait does not start a new transaction later.
- mem_addr, mem_we and mem_wdata stay stable for the whole time mem_req=1.

Test Plan:
- Reset mid-read: reset asserted while in RD_WAIT -> mem_req and stall drop immediately, without waiting for a clock edge; after reset release, a new rd edge starts a clean read.
- Zero-wait read: sel=1, pc_addr=5'h03, rd rises, memory acks in the same cycle with mem_rdata=8'hA5 -> mem_addr=03, mem_we=0; stall high for 1 cycle; rdata=A5 with a 1-cycle rdata_valid pulse; rd held 3 more cycles produces no second mem_req.
- Wait-state write: sel=0, ir_addr=5'h1E, ac_out=8'h3C, data_e=1, wr rises, ack after 3 wait cycles -> mem_we=1, mem_wdata=3C, mem_addr=1E held; stall high for 4 cycles; rdata unchanged.
- Timeout: rd rises, mem_ack never asserted, TIMEOUT=15 -> mem_req drops after 15 unacknowledged cycles; bus_err=1 and stays set; rdata keeps its old value; stall returns to 0; a following read with a prompt ack still completes.
- Illegal strobes:
  - wr rises with data_e=0 -> no mem_req, bus_err=1.
  - Separate run after reset: rd and wr rise in the same cycle -> no mem_req, bus_err=1.

Source files
------------

// File: rtl/mem_bus_if.sv
// Memory bus interface: turns controller rd/wr strobe edges into single req/ack memory transactions.
// Latency: mem_req rises one edge after a strobe edge; rdata/rdata_valid one edge after mem_ack.
// Backpressure: stall is held while a transaction waits for mem_ack; timeout aborts to ERR.
module mem_bus_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rd,
  input  logic                  wr,
  input  logic                  sel,
  input  logic                  data_e,
  input  logic [ADDR_WIDTH-1:0] pc_addr,
  input  logic [ADDR_WIDTH-1:0] ir_addr,
  input  logic [DATA_WIDTH-1:0] ac_out,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rdata_valid,
  output logic                  stall,
  output logic                  bus_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2,
    ERR     = 2'd3
  } state_t;

  // Counter is 8 bits wide because TIMEOUT may be as large as 255.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t                  state_q, state_d;
  logic [7:0]              cnt_q, cnt_d;
  logic                    rd_q, wr_q;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    req_q, req_d;
  logic                    we_q, we_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    rvalid_q, rvalid_d;
  logic                    err_q, err_d;

  logic start_rd, start_wr;

  assign start_rd = rd & ~rd_q;
  assign start_wr = wr & ~wr_q;

  // Strobe history tracks rd/wr in every state so edges seen during a wait are consumed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_q <= 1'b0;
      wr_q <= 1'b0;
    end else begin
      rd_q <= rd;
      wr_q <= wr;
    end
  end

  // State and bus registers; reset abandons any outstanding transaction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      req_q    <= req_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
    end
  end

  // Next-state logic: launch on strobe edges, finish on ack, abort on timeout.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    req_d    = req_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    err_d    = err_q;

    case (state_q)
      IDLE: begin
        if (start_rd && start_wr) begin
          // Simultaneous read and write edges are ambiguous: flag and do nothing.
          err_d = 1'b1;
        end else if (start_rd) begin
          addr_d  = sel ? pc_addr : ir_addr;
          we_d    = 1'b0;
          req_d   = 1'b1;
          cnt_d   = '0;
          state_d = RD_WAIT;
        end else if (start_wr) begin
          if (data_e) begin
            addr_d  = sel ? pc_addr : ir_addr;
            wdata_d = ac_out;
            we_d    = 1'b1;
            req_d   = 1'b1;
            cnt_d   = '0;
            state_d = WR_WAIT;
          end else begin
            // A write without the data bus enabled would store garbage.
            err_d = 1'b1;
          end
        end
      end
      RD_WAIT, WR_WAIT: begin
        if (mem_ack) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          cnt_d   = '0;
          state_d = IDLE;
          if (state_q == RD_WAIT) begin
            rdata_d  = mem_rdata;
            rvalid_d = 1'b1;
          end
        end else if (cnt_q == CNT_LAST) begin
          // This is the TIMEOUT-th cycle without an ack: give up on the access.
          req_d   = 1'b0;
          we_d    = 1'b0;
          cnt_d   = '0;
          err_d   = 1'b1;
          state_d = ERR;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ERR: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign stall       = (state_q == RD_WAIT) | (state_q == WR_WAIT);
  assign mem_addr    = addr_q;
  assign mem_req     = req_q;
  assign mem_we      = we_q;
  assign mem_wdata   = wdata_q;
  assign rdata       = rdata_q;
  assign rdata_valid = rvalid_q;
  assign bus_err     = err_q;

endmodule

// File: tb/tb_mem_bus_if.sv
// Bench for mem_bus_if: vector table for read/write/illegal-strobe flows,
// plus hand sequences for async reset, timeout and simultaneous strobes.
module tb_mem_bus_if;

  logic       clk;
  logic       reset;
  logic       rd, wr, sel, data_e;
  logic [4:0] pc_addr, ir_addr;
  logic [7:0] ac_out;
  logic [4:0] mem_addr;
  logic       mem_req, mem_we;
  logic [7:0] mem_wdata, mem_rdata;
  logic       mem_ack;
  logic [7:0] rdata;
  logic       rdata_valid, stall, bus_err;

  int n_cmp  = 0;
  int n_fail = 0;

  mem_bus_if #(.ADDR_WIDTH(5), .DATA_WIDTH(8), .TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .rd(rd), .wr(wr), .sel(sel), .data_e(data_e),
    .pc_addr(pc_addr), .ir_addr(ir_addr), .ac_out(ac_out),
    .mem_addr(mem_addr), .mem_req(mem_req), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .rdata(rdata), .rdata_valid(rdata_valid),
    .stall(stall), .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       rd, wr, sel, de;
    logic [4:0] pc, ir;
    logic [7:0] ac;
    logic       ack;
    logic [7:0] mrd;
    logic       e_req, e_we;
    logic [4:0] e_addr;
    logic [7:0] e_wdata;
    logic       e_stall, e_rv;
    logic [7:0] e_rdata;
    logic       e_err;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mk(
    input logic rd_i, wr_i, sel_i, de_i, input logic [4:0] pc_i, ir_i, input logic [7:0] ac_i,
    input logic ack_i, input logic [7:0] mrd_i,
    input logic req_e, we_e, input logic [4:0] addr_e, input logic [7:0] wdata_e,
    input logic stall_e, rv_e, input logic [7:0] rdata_e, input logic err_e);
    vec_t v;
    v.rd = rd_i; v.wr = wr_i; v.sel = sel_i; v.de = de_i;
    v.pc = pc_i; v.ir = ir_i; v.ac = ac_i; v.ack = ack_i; v.mrd = mrd_i;
    v.e_req = req_e; v.e_we = we_e; v.e_addr = addr_e; v.e_wdata = wdata_e;
    v.e_stall = stall_e; v.e_rv = rv_e; v.e_rdata = rdata_e; v.e_err = err_e;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    rd = 0; wr = 0; sel = 0; data_e = 0; pc_addr = 0; ir_addr = 0;
    ac_out = 0; mem_ack = 0; mem_rdata = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask

  initial begin
    idle_inputs();
    reset = 0;
    #1 reset = 1;
    #2;
    chk("rst_req", 32'(mem_req), 0);
    chk("rst_we", 32'(mem_we), 0);
    chk("rst_addr", 32'(mem_addr), 0);
    chk("rst_wdata", 32'(mem_wdata), 0);
    chk("rst_rdata", 32'(rdata), 0);
    chk("rst_rvalid", 32'(rdata_valid), 0);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_err", 32'(bus_err), 0);
    tick();
    reset = 0;
    tick();

    //              rd wr sel de  pc     ir     ac     ack mrd    req we addr   wdata  st rv rdata  err
    // zero-wait read from pc_addr, rd held high afterwards
    vecs[0]  = mk(1, 0, 1, 0, 5'h03, 5'h1E, 8'h00, 0, 8'h00, 1, 0, 5'h03, 8'h00, 1, 0, 8'h00, 0);
    vecs[1]  = mk(1, 0, 1, 0, 5'h03, 5'h1E, 8'h00, 1, 8'hA5, 0, 0, 5'h03, 8'h00, 0, 1, 8'hA5, 0);
    vecs[2]  = mk(1, 0, 1, 0, 5'h03, 5'h1E, 8'h00, 0, 8'h00, 0, 0, 5'h03, 8'h00, 0, 0, 8'hA5, 0);
    vecs[3]  = mk(1, 0, 1, 0, 5'h03, 5'h1E, 8'h00, 0, 8'h00, 0, 0, 5'h03, 8'h00, 0, 0, 8'hA5, 0);
    vecs[4]  = mk(1, 0, 1, 0, 5'h03, 5'h1E, 8'h00, 0, 8'h00, 0, 0, 5'h03, 8'h00, 0, 0, 8'hA5, 0);
    vecs[5]  = mk(0, 0, 1, 0, 5'h03, 5'h1E, 8'h00, 0, 8'h00, 0, 0, 5'h03, 8'h00, 0, 0, 8'hA5, 0);
    // write to ir_addr with 3 wait cycles; ir/ac change mid-wait and must not leak through
    vecs[6]  = mk(0, 1, 0, 1, 5'h03, 5'h1E, 8'h3C, 0, 8'h00, 1, 1, 5'h1E, 8'h3C, 1, 0, 8'hA5, 0);
    vecs[7]  = mk(0, 1, 0, 1, 5'h03, 5'h07, 8'h55, 0, 8'h00, 1, 1, 5'h1E, 8'h3C, 1, 0, 8'hA5, 0);
    vecs[8]  = mk(0, 1, 0, 1, 5'h03, 5'h07, 8'h55, 0, 8'h00, 1, 1, 5'h1E, 8'h3C, 1, 0, 8'hA5, 0);
    vecs[9]  = mk(0, 1, 0, 1, 5'h03, 5'h07, 8'h55, 0, 8'h00, 1, 1, 5'h1E, 8'h3C, 1, 0, 8'hA5, 0);
    vecs[10] = mk(0, 1, 0, 1, 5'h03, 5'h07, 8'h55, 1, 8'hFF, 0, 0, 5'h1E, 8'h3C, 0, 0, 8'hA5, 0);
    vecs[11] = mk(0, 0, 0, 1, 5'h03, 5'h07, 8'h55, 0, 8'h00, 0, 0, 5'h1E, 8'h3C, 0, 0, 8'hA5, 0);
    // write edge without data_e: error, no transaction
    vecs[12] = mk(0, 1, 1, 0, 5'h03, 5'h07, 8'h55, 0, 8'h00, 0, 0, 5'h1E, 8'h3C, 0, 0, 8'hA5, 1);
    vecs[13] = mk(0, 0, 1, 0, 5'h03, 5'h07, 8'h55, 0, 8'h00, 0, 0, 5'h1E, 8'h3C, 0, 0, 8'hA5, 1);

    for (int i = 0; i < 14; i++) begin
      rd = vecs[i].rd; wr = vecs[i].wr; sel = vecs[i].sel; data_e = vecs[i].de;
      pc_addr = vecs[i].pc; ir_addr = vecs[i].ir; ac_out = vecs[i].ac;
      mem_ack = vecs[i].ack; mem_rdata = vecs[i].mrd;
      tick();
      chk($sformatf("v%0d_req", i), 32'(mem_req), 32'(vecs[i].e_req));
      chk($sformatf("v%0d_we", i), 32'(mem_we), 32'(vecs[i].e_we));
      chk($sformatf("v%0d_addr", i), 32'(mem_addr), 32'(vecs[i].e_addr));
      chk($sformatf("v%0d_wdata", i), 32'(mem_wdata), 32'(vecs[i].e_wdata));
      chk($sformatf("v%0d_stall", i), 32'(stall), 32'(vecs[i].e_stall));
      chk($sformatf("v%0d_rvalid", i), 32'(rdata_valid), 32'(vecs[i].e_rv));
      chk($sformatf("v%0d_rdata", i), 32'(rdata), 32'(vecs[i].e_rdata));
      chk($sformatf("v%0d_err", i), 32'(bus_err), 32'(vecs[i].e_err));
    end

    // Timeout: first load a known rdata, then let a read go unanswered.
    do_reset();
    sel = 1; pc_addr = 5'h04; rd = 1;
    tick();
    mem_ack = 1; mem_rdata = 8'h5A;
    tick();
    chk("pre_to_rdata", 32'(rdata), 32'h5A);
    mem_ack = 0; mem_rdata = 8'h00; rd = 0;
    tick();
    rd = 1; pc_addr = 5'h09;
    tick();
    begin
      int hi;
      int guard;
      hi = 0;
      guard = 0;
      while (mem_req && guard < 40) begin
        hi++;
        tick();
        guard++;
      end
      chk("to_req_cycles", 32'(hi), 15);
    end
    chk("to_err", 32'(bus_err), 1);
    chk("to_stall", 32'(stall), 0);
    chk("to_rdata_kept", 32'(rdata), 32'h5A);
    chk("to_no_rvalid", 32'(rdata_valid), 0);
    rd = 0;
    tick();
    tick();
    chk("to_err_sticky", 32'(bus_err), 1);
    rd = 1; pc_addr = 5'h06;
    tick();
    chk("post_to_req", 32'(mem_req), 1);
    mem_ack = 1; mem_rdata = 8'hC3;
    tick();
    chk("post_to_rdata", 32'(rdata), 32'hC3);
    chk("post_to_rvalid", 32'(rdata_valid), 1);
    chk("post_to_err", 32'(bus_err), 1);
    mem_ack = 0; rd = 0;
    tick();

    // Reset mid-read drops mem_req/stall without a clock edge.
    do_reset();
    sel = 1; pc_addr = 5'h0A; rd = 1;
    tick();
    chk("mid_req_before", 32'(mem_req), 1);
    chk("mid_stall_before", 32'(stall), 1);
    #2 reset = 1;
    #1;
    chk("mid_req_async", 32'(mem_req), 0);
    chk("mid_stall_async", 32'(stall), 0);
    rd = 0;
    tick();
    reset = 0;
    tick();
    chk("mid_idle_req", 32'(mem_req), 0);
    rd = 1; pc_addr = 5'h11;
    tick();
    chk("mid_new_req", 32'(mem_req), 1);
    chk("mid_new_addr", 32'(mem_addr), 32'h11);
    mem_ack = 1; mem_rdata = 8'h77;
    tick();
    chk("mid_new_rdata", 32'(rdata), 32'h77);
    chk("mid_new_rvalid", 32'(rdata_valid), 1);
    chk("mid_new_err", 32'(bus_err), 0);
    mem_ack = 0; rd = 0;
    tick();

    // Simultaneous rd and wr edges after a fresh reset.
    do_reset();
    rd = 1; wr = 1; data_e = 1; ac_out = 8'h99;
    tick();
    chk("dual_req", 32'(mem_req), 0);
    chk("dual_stall", 32'(stall), 0);
    chk("dual_err", 32'(bus_err), 1);
    tick();
    chk("dual_req_held", 32'(mem_req), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
